// File: rtl/leaky_relu_array.sv
// Multi-lane activation pipeline (identity / ReLU / LeakyReLU / clipped ReLU), 3 stages.
// Define LEAKY_RELU_ARRAY_ROUND_EN to round the LeakyReLU product half up instead of truncating.
module leaky_relu_array #(
  parameter int LANES            = 4,
  parameter int DATA_WIDTH       = 16,
  parameter int ALPHA_WIDTH      = 16,
  parameter int INFO_ALONG_WIDTH = 2,
  parameter int SIM_DELAY        = 1
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [1:0]                    act_mode,
  input  logic [4:0]                    fixed_point_quat_accrc,
  input  logic [ALPHA_WIDTH-1:0]        act_param_alpha,
  input  logic [DATA_WIDTH-1:0]         act_clip_max,
  input  logic [LANES*DATA_WIDTH-1:0]   s_op_x,
  input  logic [LANES-1:0]              s_pass,
  input  logic [INFO_ALONG_WIDTH-1:0]   s_info_along,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [LANES*DATA_WIDTH-1:0]   m_res,
  output logic [INFO_ALONG_WIDTH-1:0]   m_info_along,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          idle
);

  // Handshake: a beat moves on s_* when s_valid & s_ready, and on m_* when m_valid & m_ready.
  // The whole pipeline advances as one unit on en, so s_ready is en itself.

  localparam int PW = DATA_WIDTH + ALPHA_WIDTH;
  // Headroom so the rounding constant (up to 2^29) can never overflow the product.
  localparam int EW = PW + 32;
  localparam logic signed [EW-1:0] SAT_MAX = {{(EW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN = {{(EW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  if (LANES < 1 || LANES > 16 || DATA_WIDTH < 8 || DATA_WIDTH > 32 ||
      ALPHA_WIDTH < 1 || INFO_ALONG_WIDTH < 1 || SIM_DELAY < 0) begin : g_param_check
    $error("leaky_relu_array: parameter out of range");
  end

  logic                          en;

  logic                          s0_valid_q, s0_valid_d;
  logic [LANES*DATA_WIDTH-1:0]   s0_x_q, s0_x_d;
  logic [LANES-1:0]              s0_pass_q, s0_pass_d;
  logic [INFO_ALONG_WIDTH-1:0]   s0_info_q, s0_info_d;

  logic                          s1_valid_q, s1_valid_d;
  logic [LANES*DATA_WIDTH-1:0]   s1_x_q, s1_x_d;
  logic [LANES*PW-1:0]           s1_prod_q, s1_prod_d;
  logic [LANES-1:0]              s1_pass_q, s1_pass_d;
  logic [INFO_ALONG_WIDTH-1:0]   s1_info_q, s1_info_d;

  logic                          m_valid_q, m_valid_d;
  logic [LANES*DATA_WIDTH-1:0]   m_res_q, m_res_d;
  logic [INFO_ALONG_WIDTH-1:0]   m_info_q, m_info_d;

  logic [LANES*PW-1:0]           prod_c;
  logic [LANES*DATA_WIDTH-1:0]   res_c;
  logic signed [EW-1:0]          ext_v, rnd_v, sc_v;
  logic signed [DATA_WIDTH-1:0]  x_v, sat_v, lane_v;

  assign en           = !m_valid_q | m_ready;
  assign s_ready      = en;
  assign m_valid      = m_valid_q;
  assign m_res        = m_res_q;
  assign m_info_along = m_info_q;
  assign idle         = !(s0_valid_q | s1_valid_q | m_valid_q);

  always_comb begin
    s0_valid_d = s0_valid_q;
    s0_x_d     = s0_x_q;
    s0_pass_d  = s0_pass_q;
    s0_info_d  = s0_info_q;
    if (en) begin
      s0_valid_d = s_valid;
      s0_x_d     = s_op_x;
      s0_pass_d  = s_pass;
      s0_info_d  = s_info_along;
    end
  end

  always_comb begin
    prod_c = '0;
    for (int i = 0; i < LANES; i++) begin
      prod_c[i*PW +: PW] = PW'($signed(s0_x_q[i*DATA_WIDTH +: DATA_WIDTH])) *
                           PW'($signed(act_param_alpha));
    end
    s1_valid_d = s1_valid_q;
    s1_x_d     = s1_x_q;
    s1_prod_d  = s1_prod_q;
    s1_pass_d  = s1_pass_q;
    s1_info_d  = s1_info_q;
    if (en) begin
      s1_valid_d = s0_valid_q;
      s1_x_d     = s0_x_q;
      s1_prod_d  = prod_c;
      s1_pass_d  = s0_pass_q;
      s1_info_d  = s0_info_q;
    end
  end

  always_comb begin
    res_c  = '0;
    ext_v  = '0;
    rnd_v  = '0;
    sc_v   = '0;
    x_v    = '0;
    sat_v  = '0;
    lane_v = '0;
    for (int i = 0; i < LANES; i++) begin
      ext_v = EW'($signed(s1_prod_q[i*PW +: PW]));
      rnd_v = '0;
`ifdef LEAKY_RELU_ARRAY_ROUND_EN
      if (fixed_point_quat_accrc != 5'd0) rnd_v[fixed_point_quat_accrc - 5'd1] = 1'b1;
`endif
      sc_v = (ext_v + rnd_v) >>> fixed_point_quat_accrc;
      if (sc_v > SAT_MAX)      sat_v = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      else if (sc_v < SAT_MIN) sat_v = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      else                     sat_v = sc_v[DATA_WIDTH-1:0];

      x_v = $signed(s1_x_q[i*DATA_WIDTH +: DATA_WIDTH]);
      if (s1_pass_q[i]) begin
        lane_v = x_v;
      end else if (!x_v[DATA_WIDTH-1]) begin
        lane_v = (act_mode == 2'b11 && x_v > $signed(act_clip_max)) ? $signed(act_clip_max) : x_v;
      end else begin
        case (act_mode)
          2'b00:   lane_v = x_v;
          2'b10:   lane_v = sat_v;
          default: lane_v = '0;
        endcase
      end
      res_c[i*DATA_WIDTH +: DATA_WIDTH] = lane_v;
    end

    m_valid_d = m_valid_q;
    m_res_d   = m_res_q;
    m_info_d  = m_info_q;
    if (en) begin
      m_valid_d = s1_valid_q;
      m_res_d   = res_c;
      m_info_d  = s1_info_q;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      s0_valid_q <= 1'b0;
      s0_x_q     <= '0;
      s0_pass_q  <= '0;
      s0_info_q  <= '0;
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_prod_q  <= '0;
      s1_pass_q  <= '0;
      s1_info_q  <= '0;
      m_valid_q  <= 1'b0;
      m_res_q    <= '0;
      m_info_q   <= '0;
    end else begin
      s0_valid_q <= s0_valid_d;
      s0_x_q     <= s0_x_d;
      s0_pass_q  <= s0_pass_d;
      s0_info_q  <= s0_info_d;
      s1_valid_q <= s1_valid_d;
      s1_x_q     <= s1_x_d;
      s1_prod_q  <= s1_prod_d;
      s1_pass_q  <= s1_pass_d;
      s1_info_q  <= s1_info_d;
      m_valid_q  <= m_valid_d;
      m_res_q    <= m_res_d;
      m_info_q   <= m_info_d;
    end
  end

endmodule

// File: doc/leaky_relu_array.md
LEAKY_RELU_ARRAY -- requirements
Module: leaky_relu_array

Interface
REQ-001 SHALL have parameter LANES, default 4, number of parallel activation lanes (1..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, signed two's-complement width of each lane operand and result (8..32).
REQ-003 SHALL have parameter ALPHA_WIDTH, default 16, signed width of act_param_alpha.
REQ-004 SHALL have parameter INFO_ALONG_WIDTH, default 2, width of side-band data carried with each beat.
REQ-005 SHALL have parameter SIM_DELAY, default 1, simulation-only delay on register assignments.
REQ-006 aclk  input  1  clock; all logic on rising edge.
REQ-007 areset  input  1  synchronous, active-high reset.
REQ-008 act_mode  input  2  00 identity, 01 ReLU, 10 LeakyReLU, 11 clipped ReLU.
REQ-009 fixed_point_quat_accrc  input  5  fraction bits of alpha (0..30).
REQ-010 act_param_alpha  input  ALPHA_WIDTH  signed fixed-point slope for negative inputs.
REQ-011 act_clip_max  input  DATA_WIDTH  signed upper bound for mode 11.
REQ-012 s_op_x  input  LANES*DATA_WIDTH  lane operands, lane 0 in LSBs.
REQ-013 s_pass  input  LANES  per-lane pass flag; set lane outputs its operand unchanged.
REQ-014 s_info_along  input  INFO_ALONG_WIDTH  side-band data.
REQ-015 s_valid / s_ready  input / output  1  upstream handshake.
REQ-016 m_res  output  LANES*DATA_WIDTH  lane results.
REQ-017 m_info_along  output  INFO_ALONG_WIDTH  side-band data of output beat.
REQ-018 m_valid / m_ready  output / input  1  downstream handshake.
REQ-019 idle  output  1  high when no stage holds a valid beat.

Function
REQ-020 SHALL implement a 3-stage pipeline: S0 input register, S1 signed multiply x*alpha per lane, S2 shift/saturate/mode-select register driving m_*.
REQ-021 Pipeline enable en = !m_valid | m_ready; all stages advance together only when en is high; bubbles are not collapsed.
REQ-022 s_ready SHALL equal en combinationally; a beat is accepted when s_valid & s_ready.
REQ-023 Latency SHALL be exactly 3 cycles from acceptance to m_valid with m_ready held high; throughput 1 beat/cycle.
REQ-024 While m_valid & !m_ready, m_res, m_info_along and m_valid SHALL hold stable.
REQ-025 Product SHALL be full width DATA_WIDTH+ALPHA_WIDTH signed; scaled = product >>> fixed_point_quat_accrc (arithmetic), then saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-026 Per lane, x >= 0: modes 00/01/10 output x; mode 11 outputs min(x, act_clip_max).
REQ-027 Per lane, x < 0: mode 00 outputs x; modes 01/11 output 0; mode 10 outputs saturated scaled product.
REQ-028 s_pass lane bit set SHALL override REQ-026/027 and output x for that lane.
REQ-029 Configuration inputs (act_mode, quat_accrc, alpha, clip_max) SHALL only change while idle; behaviour otherwise undefined.
REQ-030 s_info_along SHALL emerge unchanged aligned with its beat.

Reset
REQ-031 With areset high at a rising edge, all stage valid flags, m_valid and m_res SHALL clear to 0, m_info_along to 0, idle to 1, regardless of in-flight beats or stall.
REQ-032 Beats in flight at reset SHALL be discarded; s_ready SHALL be 1 in the cycle after reset.

Configuration
REQ-033 Macro LEAKY_RELU_ARRAY_ROUND_EN defined: add 2^(quat_accrc-1) to product before shift when quat_accrc > 0 (round half up); undefined: truncate (floor).

Verification
REQ-034 DATA_WIDTH=16, mode 10, quat_accrc=5, alpha=4: x=-40 -> -5; x=803 -> 803; x=-803 -> -101 without macro, -100 with macro.
REQ-035 Mode 10, quat_accrc=0, alpha=32767, x=-32768 -> -32768 (saturated); x=-2 -> -32768.
REQ-036 Mode 11, clip_max=100: x=803 -> 100, x=50 -> 50, x=-5 -> 0; same beat with s_pass=4'b0001 on lane 0 x=803 -> 803.
REQ-037 Back-to-back 8 beats, m_ready low cycles 4-8: outputs stable during stall, s_ready low while stalled, all 8 beats delivered in order, no loss/duplication.
REQ-038 areset asserted for 1 cycle with 3 beats in flight and m_ready low: m_valid 0 and idle 1 next cycle; following beat x=-40 emerges 3 cycles after acceptance.
